// File: rtl/deser_word_align.sv
// Per-lane word-boundary trainer for the AD9970 deserializer (recovered clock domain).
// Define DESER_SLIP_CNT_EN to expose per-lane slip counters on ov_slip_count.
module deser_word_align #(
  parameter int                     CHANNEL_NUM   = 4,
  parameter int                     DESER_WIDTH   = 6,
  parameter logic [DESER_WIDTH-1:0] TRAIN_PATTERN = 6'b111000,
  parameter int                     MATCH_COUNT   = 4,
  parameter int                     BITSLIP_WAIT  = 3,
  parameter int                     MAX_SLIP      = 12
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               i_bufpll_lock,
  input  logic                               i_train_start,
  input  logic [CHANNEL_NUM*DESER_WIDTH-1:0] iv_data_recover,
  output logic [CHANNEL_NUM-1:0]             ov_bitslip,
  output logic [CHANNEL_NUM-1:0]             ov_chan_locked,
  output logic                               o_align_done,
  output logic                               o_align_err,
  output logic [CHANNEL_NUM*DESER_WIDTH-1:0] ov_data_aligned,
  output logic                               o_data_valid
`ifdef DESER_SLIP_CNT_EN
  ,
  output logic [CHANNEL_NUM*4-1:0]           ov_slip_count
`endif
);

  localparam int MW = $clog2(MATCH_COUNT + 1);
  localparam int SW = $clog2(MAX_SLIP + 1);
  localparam int WW = $clog2(BITSLIP_WAIT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_SLIP,
    S_WAIT,
    S_LOCKED,
    S_FAIL
  } state_e;

  state_e          state_q [CHANNEL_NUM];
  state_e          state_d [CHANNEL_NUM];
  logic [MW-1:0]   match_q [CHANNEL_NUM];
  logic [MW-1:0]   match_d [CHANNEL_NUM];
  logic [SW-1:0]   slip_q  [CHANNEL_NUM];
  logic [SW-1:0]   slip_d  [CHANNEL_NUM];
  logic [WW-1:0]   wait_q  [CHANNEL_NUM];
  logic [WW-1:0]   wait_d  [CHANNEL_NUM];
  logic [CHANNEL_NUM-1:0] fail_w;

  logic                               done_q;
  logic                               err_q;
  logic [CHANNEL_NUM*DESER_WIDTH-1:0] data_q;

  always_ff @(posedge clk) begin
    for (int k = 0; k < CHANNEL_NUM; k++) begin
      if (reset) begin
        state_q[k] <= S_IDLE;
        match_q[k] <= '0;
        slip_q[k]  <= '0;
        wait_q[k]  <= '0;
      end else begin
        state_q[k] <= state_d[k];
        match_q[k] <= match_d[k];
        slip_q[k]  <= slip_d[k];
        wait_q[k]  <= wait_d[k];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < CHANNEL_NUM; k++) begin
      state_d[k] = state_q[k];
      match_d[k] = match_q[k];
      slip_d[k]  = slip_q[k];
      wait_d[k]  = wait_q[k];
      // lock loss outranks a start pulse; both clear every counter
      if (!i_bufpll_lock) begin
        state_d[k] = S_IDLE;
        match_d[k] = '0;
        slip_d[k]  = '0;
        wait_d[k]  = '0;
      end else if (i_train_start) begin
        state_d[k] = S_CHECK;
        match_d[k] = '0;
        slip_d[k]  = '0;
        wait_d[k]  = '0;
      end else begin
        unique case (state_q[k])
          S_CHECK: begin
            if (iv_data_recover[k*DESER_WIDTH +: DESER_WIDTH]
                == TRAIN_PATTERN) begin
              match_d[k] = match_q[k] + 1'b1;
              if (match_q[k] == MW'(MATCH_COUNT - 1))
                state_d[k] = S_LOCKED;
            end else begin
              match_d[k] = '0;
              state_d[k] = (slip_q[k] == SW'(MAX_SLIP)) ? S_FAIL : S_SLIP;
            end
          end
          S_SLIP: begin
            if (slip_q[k] != SW'(MAX_SLIP))
              slip_d[k] = slip_q[k] + 1'b1;
            wait_d[k]  = '0;
            state_d[k] = S_WAIT;
          end
          S_WAIT: begin
            if (wait_q[k] == WW'(BITSLIP_WAIT - 1))
              state_d[k] = S_CHECK;
            else
              wait_d[k] = wait_q[k] + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    ov_bitslip     = '0;
    ov_chan_locked = '0;
    fail_w         = '0;
    for (int k = 0; k < CHANNEL_NUM; k++) begin
      ov_bitslip[k]     = (state_q[k] == S_SLIP);
      ov_chan_locked[k] = (state_q[k] == S_LOCKED);
      fail_w[k]         = (state_q[k] == S_FAIL);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      data_q <= '0;
    end else begin
      data_q <= iv_data_recover;
      if (!i_bufpll_lock || i_train_start) begin
        done_q <= 1'b0;
        err_q  <= 1'b0;
      end else begin
        done_q <= &ov_chan_locked;
        err_q  <= |fail_w;
      end
    end
  end

  assign o_align_done    = done_q;
  assign o_align_err     = err_q;
  assign o_data_valid    = done_q;
  assign ov_data_aligned = data_q;

`ifdef DESER_SLIP_CNT_EN
  always_comb begin
    ov_slip_count = '0;
    for (int k = 0; k < CHANNEL_NUM; k++) begin
      ov_slip_count[k*4 +: 4] =
        (32'(slip_q[k]) > 32'd15) ? 4'hF : 4'(slip_q[k]);
    end
  end
`endif

endmodule

// File: tb/tb_deser_word_align.sv
// Directed bench for deser_word_align with a bitslip-aware lane model.
// Checks ov_slip_count as well when DESER_SLIP_CNT_EN is defined.
module tb_deser_word_align;
  localparam int CH = 4;
  localparam int W  = 6;

  logic            clk = 1'b0;
  logic            reset;
  logic            lock;
  logic            start;
  logic [CH*W-1:0] iv;
  logic [CH*W-1:0] ov_data;
  logic [CH-1:0]   bitslip;
  logic [CH-1:0]   locked;
  logic            done;
  logic            err;
  logic            valid;
`ifdef DESER_SLIP_CNT_EN
  logic [CH*4-1:0] slip_cnt;
`endif

  always #5 clk = ~clk;

  deser_word_align dut (
    .clk             (clk),
    .reset           (reset),
    .i_bufpll_lock   (lock),
    .i_train_start   (start),
    .iv_data_recover (iv),
    .ov_bitslip      (bitslip),
    .ov_chan_locked  (locked),
    .o_align_done    (done),
    .o_align_err     (err),
    .ov_data_aligned (ov_data),
    .o_data_valid    (valid)
`ifdef DESER_SLIP_CNT_EN
    ,
    .ov_slip_count   (slip_cnt)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // deserializer model: each bitslip rotates the lane word by one bit
  logic [5:0]    pat = 6'b111000;
  int            phase      [CH];
  int            init_phase [CH];
  logic [CH-1:0] force_en;
  logic [5:0]    force_val  [CH];

  function automatic logic [5:0] rotl(input logic [5:0] w, input int n);
    logic [5:0] r;
    r = w;
    for (int i = 0; i < n; i++) r = {r[4:0], r[5]};
    return r;
  endfunction

  always_comb begin
    iv = '0;
    for (int k = 0; k < CH; k++)
      iv[k*W +: W] = force_en[k] ? force_val[k] : rotl(pat, phase[k]);
  end

  int   cyc = 0;
  int   cnt  [CH];
  int   gap  [CH];
  int   last [CH];
  logic seen [CH];
  logic clr_mon;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < CH; k++) begin
      if (reset) phase[k] <= init_phase[k];
      else if (bitslip[k]) phase[k] <= (phase[k] + 1) % 6;
      if (clr_mon) begin
        cnt[k]  <= 0;
        gap[k]  <= 999;
        seen[k] <= 1'b0;
      end else if (bitslip[k]) begin
        cnt[k] <= cnt[k] + 1;
        if (seen[k] && (cyc - last[k] < gap[k])) gap[k] <= cyc - last[k];
        last[k] <= cyc;
        seen[k] <= 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic clear_mon();
    clr_mon = 1'b1;
    tick();
    clr_mon = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: no finish by %0t", $time);
    $fatal(1);
  end

  initial begin
    reset    = 1'b1;
    lock     = 1'b0;
    start    = 1'b0;
    force_en = '0;
    clr_mon  = 1'b1;
    for (int k = 0; k < CH; k++) begin
      init_phase[k] = 0;
      force_val[k]  = '0;
    end
    ticks(2);
    check("rst_bitslip", bitslip, 0);
    check("rst_locked", locked, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_valid", valid, 0);
    check("rst_data", ov_data, 0);
    reset   = 1'b0;
    clr_mon = 1'b0;

    // data register runs regardless of training state
    lock      = 1'b1;
    force_en  = 4'hF;
    force_val = '{6'h15, 6'h2A, 6'h3F, 6'h01};
    tick();
    check("echo_idle", ov_data, 24'h07FA95);
    check("idle_locked", locked, 0);

    // start with lock low is ignored
    force_en = '0;
    lock     = 1'b0;
    start    = 1'b1;
    tick();
    start = 1'b0;
    lock  = 1'b1;
    ticks(6);
    check("nolock_start_locked", locked, 0);
    check("nolock_start_done", done, 0);

    // scenario 1: clean lock
    clear_mon();
    pulse_start();
    check("s1_k1_locked", locked, 0);
    ticks(3);
    check("s1_k4_locked", locked, 0);
    tick();
    check("s1_k5_locked", locked, 4'hF);
    check("s1_k5_done", done, 0);
    tick();
    check("s1_k6_done", done, 1);
    check("s1_k6_valid", valid, 1);
    check("s1_data", ov_data, 24'hE38E38);
    force_en  = 4'hF;
    force_val = '{6'h3F, 6'h3F, 6'h3F, 6'h3F};
    check("s1_latency", ov_data, 24'hE38E38);
    tick();
    check("s1_data_new", ov_data, 24'hFFFFFF);
    check("s1_hold_locked", locked, 4'hF);
    check("s1_hold_done", done, 1);
    check("s1_slips", cnt[0] + cnt[1] + cnt[2] + cnt[3], 0);

    // restart from LOCKED
    force_en = '0;
    pulse_start();
    check("s5a_locked_clr", locked, 0);
    check("s5a_done_clr", done, 0);
    check("s5a_valid_clr", valid, 0);
    ticks(4);
    check("s5a_relock", locked, 4'hF);
    tick();
    check("s5a_redone", done, 1);

    // scenario 2: lane 2 three slips off
    init_phase[2] = 3;
    pulse_reset();
    clear_mon();
    pulse_start();
    ticks(4);
    check("s2_k5_locked", locked, 4'b1011);
    ticks(14);
    check("s2_k19_locked", locked, 4'b1011);
    check("s2_k19_done", done, 0);
    tick();
    check("s2_k20_locked", locked, 4'hF);
    tick();
    check("s2_k21_done", done, 1);
    ticks(5);
    check("s2_slips2", cnt[2], 3);
    check("s2_gap2", gap[2], 5);
    check("s2_slips_other", cnt[0] + cnt[1] + cnt[3], 0);
`ifdef DESER_SLIP_CNT_EN
    check("s6_slip_count", slip_cnt, 16'h0300);
`endif

    // scenario 3: lane 1 never matches
    init_phase[2] = 0;
    force_en      = 4'b0010;
    force_val[1]  = 6'h00;
    pulse_reset();
    clear_mon();
    pulse_start();
    ticks(61);
    check("s3_k62_locked", locked, 4'b1101);
    check("s3_k62_err", err, 0);
    tick();
    check("s3_k63_err", err, 1);
    check("s3_k63_done", done, 0);
    check("s3_k63_valid", valid, 0);
    check("s3_k63_locked", locked, 4'b1101);
    ticks(17);
    check("s3_slips1", cnt[1], 12);
    check("s3_gap1", gap[1], 5);
`ifdef DESER_SLIP_CNT_EN
    check("s3_slip_count", slip_cnt, 16'h00C0);
`endif

    // restart from FAIL
    clear_mon();
    pulse_start();
    check("s5b_err_clr", err, 0);
    check("s5b_locked_clr", locked, 0);
    ticks(62);
    check("s5b_err", err, 1);
    check("s5b_locked", locked, 4'b1101);
    ticks(17);
    check("s5b_slips1", cnt[1], 12);

    // scenario 4: lock drop while lane 0 waits
    force_en      = '0;
    init_phase[0] = 1;
    pulse_reset();
    clear_mon();
    pulse_start();
    tick();
    check("s4_slip0", bitslip, 4'b0001);
    tick();
    lock = 1'b0;
    tick();
    check("s4_bitslip", bitslip, 0);
    check("s4_locked", locked, 0);
    check("s4_done", done, 0);
    check("s4_err", err, 0);
    check("s4_valid", valid, 0);
    clear_mon();
    lock = 1'b1;
    ticks(20);
    check("s4_relock_locked", locked, 0);
    check("s4_relock_done", done, 0);
    check("s4_relock_valid", valid, 0);
    check("s4_no_slips", cnt[0] + cnt[1] + cnt[2] + cnt[3], 0);

    // reset asserted while lane 2 is in SLIP
    init_phase[0] = 0;
    init_phase[2] = 3;
    pulse_reset();
    pulse_start();
    tick();
    check("s5c_in_slip", bitslip, 4'b0100);
    reset = 1'b1;
    tick();
    check("s5c_bitslip", bitslip, 0);
    check("s5c_locked", locked, 0);
    check("s5c_done", done, 0);
    check("s5c_err", err, 0);
    check("s5c_valid", valid, 0);
    check("s5c_data", ov_data, 0);
    reset = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/deser_word_align.md
Name: deser_word_align

Overview:
- Sits directly downstream of the AD9970 LVDS deserializer wrapper, in the recovered-clock domain.
- Consumes the raw parallel words and their PLL-lock status.
- Trains each channel's word boundary by issuing bitslip pulses back to the deserializer until a known training pattern is seen.
- Forwards aligned parallel data with a valid flag to the pixel pipeline.

Parameters:
- CHANNEL_NUM, 4, number of serial data lanes.
- DESER_WIDTH, 6, bits per deserialized word per lane.
- TRAIN_PATTERN, 6'b111000, expected word per lane during training (DESER_WIDTH bits).
- MATCH_COUNT, 4, consecutive pattern matches required to declare a lane locked (range 1..15).
- BITSLIP_WAIT, 3, idle cycles after each bitslip pulse before comparison resumes (range 1..15).
- MAX_SLIP, 12, bitslips allowed per lane before that lane is declared failed.

Ports:
- clk, input, 1, recovered parallel clock; sole clock.
- reset, input, 1, synchronous, active-high.
- i_bufpll_lock, input, 1, deserializer clock-PLL lock.
- i_train_start, input, 1, single-cycle pulse that starts or restarts training.
- iv_data_recover, input, CHANNEL_NUM*DESER_WIDTH, deserialized words; lane k occupies bits [k*DESER_WIDTH +: DESER_WIDTH].
- ov_bitslip, output, CHANNEL_NUM, one-cycle bitslip pulse per lane, to the deserializer.
- ov_chan_locked, output, CHANNEL_NUM, per-lane locked flag.
- o_align_done, output, 1, all lanes locked.
- o_align_err, output, 1, at least one lane failed.
- ov_data_aligned, output, CHANNEL_NUM*DESER_WIDTH, registered copy of iv_data_recover.
- o_data_valid, output, 1, ov_data_aligned is usable.

Behaviour:
- Reset values: all outputs 0. Every lane FSM is in IDLE. All counters are 0.
- One independent FSM per lane, with states IDLE, CHECK, SLIP, WAIT, LOCKED, FAIL.
- IDLE:
  - Move to CHECK when i_train_start=1 and i_bufpll_lock=1 in the same cycle.
  - Clear the match and slip counters on that transition.
  - i_train_start with lock low is ignored.
- CHECK: compare the lane word with TRAIN_PATTERN every cycle.
  - On a match, increment the match counter. When the counter reaches MATCH_COUNT, go to LOCKED on the next edge.
  - On a mismatch, clear the match counter and go to SLIP. If the slip counter already equals MAX_SLIP, go to FAIL instead.
- SLIP: lasts exactly one cycle.
  - ov_bitslip[k]=1 during this cycle only.
  - Increment the slip counter, then go to WAIT.
- WAIT: hold for BITSLIP_WAIT cycles, then return to CHECK. ov_bitslip[k]=0 throughout.
- LOCKED:
  - ov_chan_locked[k]=1.
  - Stay locked regardless of subsequent data.
- FAIL:
  - ov_chan_locked[k]=0.
  - Stay in FAIL until i_train_start or reset.
- Restart: i_train_start=1 with lock high, in any state, forces every lane to CHECK with counters cleared. This takes priority over all other transitions except lock loss and reset.
- Lock loss: i_bufpll_lock=0 in any cycle does all of the following on the next edge:
  - Every lane goes to IDLE.
  - ov_bitslip=0, ov_chan_locked=0.
  - o_align_done=0, o_align_err=0, o_data_valid=0.
- Priority order: reset > lock loss > i_train_start > normal transitions.
- Timing of a clean lock: with a start pulse in cycle N and a matching pattern from N+1, the lane is in CHECK at N+1, MATCH_COUNT matches are counted over N+1..N+MATCH_COUNT, and the lane is LOCKED at N+MATCH_COUNT+1.
- Status flags are registered and follow the lane states by 1 cycle:
  - o_align_done = AND of all lanes LOCKED.
  - o_align_err = OR of all lanes FAIL.
- Data path:
  - ov_data_aligned <= iv_data_recover every cycle; latency 1.
  - o_data_valid = o_align_done.
  - The data register is not gated by state.
- Counter widths: sized to hold MAX_SLIP, MATCH_COUNT and BITSLIP_WAIT without wrap. The slip counter saturates and never wraps.

Optional Feature:
- Macro: DESER_SLIP_CNT_EN.
- Defined:
  - Adds output ov_slip_count, width CHANNEL_NUM*4, carrying each lane's slip counter in lane order, saturating at 15.
  - It is cleared by reset, lock loss and i_train_start, and holds its value in LOCKED and FAIL.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
1. Clean lock: reset, lock=1, start pulse at cycle 10, all lanes =6'b111000 → no ov_bitslip pulses; ov_chan_locked=4'hF at cycle 15; o_align_done=1 and o_data_valid=1 at cycle 16; data echoed with 1-cycle latency.
2. Lane 2 offset needing 3 slips (model rotates the lane-2 word on each bitslip) → exactly 3 single-cycle pulses on ov_bitslip[2], consecutive pulses at least BITSLIP_WAIT+2 cycles apart; lanes 0/1/3 lock without slipping; o_align_done=1 after lane 2 locks.
3. Lane 1 never matches → 12 pulses on ov_bitslip[1], then lane 1 enters FAIL; o_align_err=1, o_align_done=0, ov_chan_locked=4'b1101.
4. Lock drop during WAIT on lane 0 → next cycle all outputs 0, all lanes IDLE, no further bitslips; lock restored without a start pulse → outputs stay 0.
5. Restart from LOCKED or FAIL: i_train_start pulse → flags clear within 1 cycle and training rerun gives the same results as scenarios 1/3; synchronous reset asserted mid-SLIP → all outputs 0 on the next edge.
6. With DESER_SLIP_CNT_EN defined, rerun scenario 2 → ov_slip_count lane 2 = 3 and other lanes 0; without the macro, the build has no ov_slip_count port and scenario 2 behaviour is unchanged.
